squeeze_stream: RTL and testbench

//  Squeeze-phase output stage; sits downstream of the Keccak-f permutation, mirroring the absorb stage.

---
 rtl/squeeze_stream_if.sv | 13 +
 rtl/squeeze_stream.sv | 177 +++++++++++++++++
 tb/tb_squeeze_stream.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/squeeze_stream_if.sv
// AXI-Stream output bundle of the Keccak squeeze stage.
interface squeeze_stream_if #(
  parameter int unsigned DWIDTH = 256
) ();
  logic [DWIDTH-1:0]   t_data;
  logic [DWIDTH/8-1:0] t_keep;
  logic                t_valid;
  logic                t_last;
  logic                t_ready;

  modport master (output t_data, output t_keep, output t_valid, output t_last, input t_ready);
  modport slave  (input t_data, input t_keep, input t_valid, input t_last, output t_ready);
endinterface

// File: rtl/squeeze_stream.sv
// Keccak squeeze stage: captures the permuted state and streams the first out_len rate bytes,
// requesting further permutations whenever a rate block runs out.
module squeeze_stream #(
  parameter int unsigned DWIDTH        = 256,
  parameter int unsigned LANE_SIZE     = 64,
  parameter int unsigned RATE_WIDTH    = 11,
  parameter int unsigned OUT_LEN_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic [RATE_WIDTH-1:0]               rate_i,
  input  logic [OUT_LEN_WIDTH-1:0]            out_len_i,
  input  logic [4:0][4:0][LANE_SIZE-1:0]      state_array_i,
  input  logic                                state_valid_i,
  output logic                                perm_req_o,
  output logic                                busy_o,
  squeeze_stream_if.master                    axis
);

  localparam int unsigned NBYTES  = DWIDTH / 8;
  localparam int unsigned STATE_W = 25 * LANE_SIZE;
  localparam int unsigned LW      = OUT_LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_STATE, EMIT, PERM_REQ} state_e;

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  lin_q, lin_d;
  logic [LW-1:0]       rb_q, rb_d, off_q, off_d, rem_q, rem_d;
  logic                busy_q, busy_d, perm_req_q, perm_req_d;
  logic                t_valid_q, t_valid_d, t_last_q, t_last_d;
  logic [DWIDTH-1:0]   t_data_q, t_data_d;
  logic [NBYTES-1:0]   t_keep_q, t_keep_d;

  logic [STATE_W-1:0]  cap_lin, src_lin;
  logic [LW-1:0]       cur_nb, rem_n, off_n, src_off, src_rem, src_nb;
  logic [DWIDTH-1:0]   shifted, beat_data;
  logic [NBYTES-1:0]   beat_keep;
  logic                beat_last, hs;

  // Rate byte n lives in lane n/8; lane k sits at x=k%5, y=k/5.
  function automatic logic [STATE_W-1:0] linearize(input logic [4:0][4:0][LANE_SIZE-1:0] s);
    logic [STATE_W-1:0] l;
    l = '0;
    for (int k = 0; k < 25; k++) l[k*LANE_SIZE +: LANE_SIZE] = s[3'(k % 5)][3'(k / 5)];
    return l;
  endfunction

  function automatic logic [LW-1:0] beat_bytes(input logic [LW-1:0] off, input logic [LW-1:0] rem,
                                               input logic [LW-1:0] rb);
    logic [LW-1:0] nb, avail;
    nb    = LW'(NBYTES);
    avail = rb - off;
    if (avail < nb) nb = avail;
    if (rem < nb)   nb = rem;
    return nb;
  endfunction

  assign hs = t_valid_q && axis.t_ready;

  // Next-beat builder: from the incoming state on capture, else from the stored copy past this beat.
  always_comb begin
    cap_lin = linearize(state_array_i);
    cur_nb  = beat_bytes(off_q, rem_q, rb_q);
    rem_n   = rem_q - cur_nb;
    off_n   = off_q + cur_nb;
    src_lin = (state_q == EMIT) ? lin_q : cap_lin;
    src_off = (state_q == EMIT) ? off_n : off_q;
    src_rem = (state_q == EMIT) ? rem_n : rem_q;
    src_nb  = beat_bytes(src_off, src_rem, rb_q);
    shifted = DWIDTH'(src_lin >> {src_off, 3'b000});
    for (int j = 0; j < NBYTES; j++) begin
      beat_keep[j]        = (LW'(j) < src_nb);
      beat_data[8*j +: 8] = shifted[8*j +: 8] & {8{beat_keep[j]}};
    end
    beat_last = (src_rem == src_nb);
  end

  always_comb begin
    state_d    = state_q;
    lin_d      = lin_q;
    rb_d       = rb_q;
    off_d      = off_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    perm_req_d = perm_req_q;
    t_valid_d  = t_valid_q;
    t_last_d   = t_last_q;
    t_data_d   = t_data_q;
    t_keep_d   = t_keep_q;
    case (state_q)
      IDLE: begin
        if (start_i && (out_len_i != '0)) begin
          rb_d    = LW'(rate_i >> 3);
          rem_d   = out_len_i;
          off_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_STATE;
        end
      end
      WAIT_STATE, PERM_REQ: begin
        if (state_valid_i) begin
          lin_d      = cap_lin;
          perm_req_d = 1'b0;
          t_valid_d  = 1'b1;
          t_data_d   = beat_data;
          t_keep_d   = beat_keep;
          t_last_d   = beat_last;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          rem_d = rem_n;
          off_d = off_n;
          if (rem_n == '0) begin
            t_valid_d = 1'b0;
            t_data_d  = '0;
            t_keep_d  = '0;
            t_last_d  = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else if (off_n == rb_q) begin
            off_d      = '0;
            t_valid_d  = 1'b0;
            t_data_d   = '0;
            t_keep_d   = '0;
            t_last_d   = 1'b0;
            perm_req_d = 1'b1;
            state_d    = PERM_REQ;
          end else begin
            t_data_d = beat_data;
            t_keep_d = beat_keep;
            t_last_d = beat_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lin_q      <= '0;
      rb_q       <= '0;
      off_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      perm_req_q <= 1'b0;
      t_valid_q  <= 1'b0;
      t_last_q   <= 1'b0;
      t_data_q   <= '0;
      t_keep_q   <= '0;
    end else begin
      state_q    <= state_d;
      lin_q      <= lin_d;
      rb_q       <= rb_d;
      off_q      <= off_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      perm_req_q <= perm_req_d;
      t_valid_q  <= t_valid_d;
      t_last_q   <= t_last_d;
      t_data_q   <= t_data_d;
      t_keep_q   <= t_keep_d;
    end
  end

  assign axis.t_valid = t_valid_q;
  assign axis.t_data  = t_data_q;
  assign axis.t_keep  = t_keep_q;
  assign axis.t_last  = t_last_q;
  assign perm_req_o   = perm_req_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_squeeze_stream.sv
// Directed bench for squeeze_stream: reset, single/multi-block streams, stalls, ignored starts, mid-run reset.
module tb_squeeze_stream;

  typedef logic [4:0][4:0][63:0] state_t;

  logic        clk, rst, start, state_valid, perm_req, busy;
  logic [10:0] rate;
  logic [15:0] out_len;
  state_t      state_arr;
  int          errors = 0;
  int          checks = 0;

  squeeze_stream_if #(.DWIDTH(256)) axis ();

  squeeze_stream dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .rate_i        (rate),
    .out_len_i     (out_len),
    .state_array_i (state_arr),
    .state_valid_i (state_valid),
    .perm_req_o    (perm_req),
    .busy_o        (busy),
    .axis          (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rate byte n (lane n/8, byte n%8, lane k at x=k%5,y=k/5) holds n+seed.
  function automatic state_t mk_state(input int seed);
    state_t s;
    for (int k = 0; k < 25; k++)
      for (int b = 0; b < 8; b++) s[k % 5][k / 5][8*b +: 8] = 8'(8*k + b + seed);
    return s;
  endfunction

  function automatic logic [255:0] exp_bytes(input int off, input int nb, input int seed);
    logic [255:0] d;
    d = '0;
    for (int j = 0; j < nb; j++) d[8*j +: 8] = 8'(off + j + seed);
    return d;
  endfunction

  task automatic do_start(input logic [10:0] r, input logic [15:0] len);
    start = 1'b1; rate = r; out_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_state(input state_t s);
    state_arr = s; state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; rate = '0; out_len = '0; state_arr = '0; state_valid = 0;
    axis.t_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({axis.t_valid, axis.t_last, perm_req, busy} !== 4'b0 || axis.t_keep !== '0 || axis.t_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b last=%b perm=%b busy=%b keep=%h (all required 0)",
               axis.t_valid, axis.t_last, perm_req, busy, axis.t_keep);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    state_t s;
    for (int k = 0; k < 25; k++) s[k % 5][k / 5] = 64'(k);
    do_start(11'd1088, 16'd32);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    pulse_state(s);
    checks++;
    if (axis.t_valid !== 1'b1) begin errors++; $display("FAIL single_latency valid got %b exp 1", axis.t_valid); end
    axis.t_ready = 1'b1;
    checks++;
    if (axis.t_data !== {64'd3, 64'd2, 64'd1, 64'd0} || axis.t_keep !== 32'hFFFF_FFFF || axis.t_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat data=%h keep=%h last=%b exp lanes 3..0 keep ffffffff last 1",
               axis.t_data, axis.t_keep, axis.t_last);
    end
    @(negedge clk);
    axis.t_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || axis.t_valid !== 1'b0 || perm_req !== 1'b0) begin
      errors++;
      $display("FAIL single_done busy=%b valid=%b perm=%b exp 0 0 0", busy, axis.t_valid, perm_req);
    end
  endtask

  task automatic test_stream(input string name, input logic [10:0] r, input logic [15:0] len,
                             input int nbs[16], input int n, input bit toggle);
    int rb, off, seed, gap;
    bit got, held, seen;
    logic [255:0] hd, od, ed;
    logic [31:0]  hk, ok, ek;
    logic         hl, ol;
    rb = int'(r) / 8; off = 0; seed = 0;
    axis.t_ready = 1'b0;
    do_start(r, len);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b exp 1", name, busy); end
    pulse_state(mk_state(seed));
    checks++;
    if (axis.t_valid !== 1'b1) begin errors++; $display("FAIL %s latency valid got %b exp 1", name, axis.t_valid); end
    for (int i = 0; i < n; i++) begin
      if (i > 0 && off == rb) begin
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge clk);
          axis.t_ready = 1'b0;
          if (perm_req === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s perm_req beat%0d got 0 exp 1", name, i); end
        seed += 64;
        off = 0;
        pulse_state(mk_state(seed));
        checks++;
        if (axis.t_valid !== 1'b1 || perm_req !== 1'b0) begin
          errors++;
          $display("FAIL %s recapture valid=%b perm=%b exp 1 0", name, axis.t_valid, perm_req);
        end
      end
      got = 0; held = 0; gap = -1;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        axis.t_ready = toggle ? ~axis.t_ready : 1'b1;
        if (held) begin
          checks++;
          held = 0;
          if (axis.t_valid !== 1'b1 || axis.t_data !== hd || axis.t_keep !== hk || axis.t_last !== hl) begin
            errors++;
            $display("FAIL %s stall_hold beat%0d valid=%b keep=%h last=%b exp valid 1 keep %h last %b",
                     name, i, axis.t_valid, axis.t_keep, axis.t_last, hk, hl);
          end
        end
        if (axis.t_valid === 1'b1) begin
          if (axis.t_ready) begin
            got = 1; gap = c; od = axis.t_data; ok = axis.t_keep; ol = axis.t_last;
          end else begin
            held = 1; hd = axis.t_data; hk = axis.t_keep; hl = axis.t_last;
          end
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL %s beat%0d timeout got no beat exp %0d bytes", name, i, nbs[i]);
      end else begin
        ed = exp_bytes(off, nbs[i], seed);
        ek = '0;
        for (int j = 0; j < nbs[i]; j++) ek[j] = 1'b1;
        if (od !== ed || ok !== ek || ol !== (i == n - 1) || perm_req !== 1'b0) begin
          errors++;
          $display("FAIL %s beat%0d data=%h keep=%h last=%b perm=%b exp data=%h keep=%h last=%b perm=0",
                   name, i, od, ok, ol, perm_req, ed, ek, (i == n - 1));
        end
        if (!toggle) begin
          checks++;
          if (gap !== 0) begin errors++; $display("FAIL %s throughput beat%0d gap=%0d exp 0", name, i, gap); end
        end
      end
      off += nbs[i];
    end
    @(negedge clk);
    axis.t_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || axis.t_valid !== 1'b0 || perm_req !== 1'b0) begin
      errors++;
      $display("FAIL %s end busy=%b valid=%b perm=%b exp 0 0 0", name, busy, axis.t_valid, perm_req);
    end
  endtask

  task automatic test_len_zero_and_busy();
    do_start(11'd576, 16'd0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || axis.t_valid !== 1'b0) begin
      errors++; $display("FAIL len_zero busy=%b valid=%b exp 0 0", busy, axis.t_valid);
    end
    do_start(11'd576, 16'd8);
    do_start(11'd1344, 16'd100);
    pulse_state(mk_state(3));
    axis.t_ready = 1'b1;
    checks++;
    if (axis.t_valid !== 1'b1 || axis.t_keep !== 32'h0000_00FF || axis.t_last !== 1'b1 ||
        axis.t_data !== exp_bytes(0, 8, 3)) begin
      errors++;
      $display("FAIL start_while_busy valid=%b keep=%h last=%b data=%h exp 1 000000ff 1 %h",
               axis.t_valid, axis.t_keep, axis.t_last, axis.t_data, exp_bytes(0, 8, 3));
    end
    @(negedge clk);
    axis.t_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || axis.t_valid !== 1'b0) begin
      errors++; $display("FAIL busy_end busy=%b valid=%b exp 0 0", busy, axis.t_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_start(11'd1088, 16'd300);
    pulse_state(mk_state(0));
    axis.t_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    axis.t_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (axis.t_valid !== 1'b1 || axis.t_data !== exp_bytes(64, 32, 0)) begin
      errors++; $display("FAIL mid_third_beat valid=%b data=%h exp 1 %h", axis.t_valid, axis.t_data, exp_bytes(64, 32, 0));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (axis.t_valid !== 1'b0 || perm_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset valid=%b perm=%b busy=%b exp 0 0 0", axis.t_valid, perm_req, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(11'd1088, 16'd32);
    pulse_state(mk_state(5));
    axis.t_ready = 1'b1;
    checks++;
    if (axis.t_valid !== 1'b1 || axis.t_keep !== 32'hFFFF_FFFF || axis.t_last !== 1'b1 ||
        axis.t_data !== exp_bytes(0, 32, 5)) begin
      errors++;
      $display("FAIL post_reset_beat valid=%b keep=%h last=%b data=%h exp 1 ffffffff 1 %h",
               axis.t_valid, axis.t_keep, axis.t_last, axis.t_data, exp_bytes(0, 32, 5));
    end
    @(negedge clk);
    axis.t_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || axis.t_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_end busy=%b valid=%b exp 0 0", busy, axis.t_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_beat();
    test_stream("r1344_l200", 11'd1344, 16'd200, '{32,32,32,32,32,8,32,0,0,0,0,0,0,0,0,0}, 7, 1'b0);
    test_stream("r576_l64", 11'd576, 16'd64, '{32,32,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, 2, 1'b0);
    test_stream("r1088_l300_stall", 11'd1088, 16'd300, '{32,32,32,32,8,32,32,32,32,8,28,0,0,0,0,0}, 11, 1'b1);
    test_len_zero_and_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
